// File: rtl/menu_navigator.sv
`default_nettype none
// ============================================================================
// menu_navigator : per-field wrap-around option indices, field select, display
//                  handshake; hold-to-repeat compiled in with MENU_AUTOREPEAT_EN
// Revision 1.0
// ============================================================================
module menu_navigator #(
    parameter int FIELDS        = 5,
    parameter int IDX_W         = 4,
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      right_arrow_pressed,
    input  logic                      left_arrow_pressed,
    input  logic                      field_next_pressed,
    input  logic                      load_initial,
    input  logic [FIELDS*IDX_W-1:0]   field_limits,
    output logic [FIELDS*IDX_W-1:0]   field_values,
    output logic [$clog2(FIELDS)-1:0] active_field,
    output logic                      changed,
    output logic [IDX_W-1:0]          arduino_out,
    output logic                      arduino_valid,
    input  logic                      arduino_ack
);
    localparam int AF_W = $clog2(FIELDS);
    localparam logic [AF_W-1:0] LAST_FIELD = AF_W'(FIELDS - 1);

    logic [FIELDS-1:0][IDX_W-1:0] vals;
    logic [FIELDS-1:0][IDX_W-1:0] vals_next;
    logic [FIELDS-1:0][IDX_W-1:0] limits;
    logic [AF_W-1:0]              active;
    logic [AF_W-1:0]              active_next;
    logic                         prev_right;
    logic                         prev_left;
    logic                         prev_field;
    logic                         rise_right;
    logic                         rise_left;
    logic                         rise_field;
    logic                         one_arrow;
    logic                         repeat_tick;
    logic                         step_up;
    logic                         step_down;
    logic                         clamp_any;
    logic                         change;

    assign limits       = field_limits;
    assign field_values = vals;
    assign active_field = active;

    assign rise_right = right_arrow_pressed & ~prev_right;
    assign rise_left  = left_arrow_pressed  & ~prev_left;
    assign rise_field = field_next_pressed  & ~prev_field;
    // Both arrows together cancel: no step and the repeat engine idles.
    assign one_arrow  = right_arrow_pressed ^ left_arrow_pressed;
    assign step_up    = one_arrow & right_arrow_pressed & (rise_right | repeat_tick);
    assign step_down  = one_arrow & left_arrow_pressed  & (rise_left  | repeat_tick);

`ifdef MENU_AUTOREPEAT_EN
    localparam int MAX_WAIT = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        REP_IDLE = 2'd0,
        REP_HOLD = 2'd1,
        REP_RUN  = 2'd2
    } rep_state_t;

    rep_state_t       rep_state;
    rep_state_t       rep_state_next;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_state <= REP_IDLE;
            rep_cnt   <= '0;
        end else begin
            rep_state <= rep_state_next;
            rep_cnt   <= rep_cnt_next;
        end
    end

    // rep_cnt holds cycles since the last step; a held arrow only counts after an edge-step.
    always_comb begin
        rep_state_next = rep_state;
        rep_cnt_next   = rep_cnt;
        repeat_tick    = 1'b0;
        if (load_initial || !one_arrow) begin
            rep_state_next = REP_IDLE;
            rep_cnt_next   = '0;
        end else if (rise_right || rise_left) begin
            rep_state_next = REP_HOLD;
            rep_cnt_next   = CNT_W'(1);
        end else begin
            case (rep_state)
                REP_HOLD: begin
                    if (rep_cnt == CNT_W'(HOLD_DELAY)) begin
                        repeat_tick    = 1'b1;
                        rep_state_next = REP_RUN;
                        rep_cnt_next   = CNT_W'(1);
                    end else begin
                        rep_cnt_next = rep_cnt + CNT_W'(1);
                    end
                end
                REP_RUN: begin
                    if (rep_cnt == CNT_W'(REPEAT_PERIOD)) begin
                        repeat_tick  = 1'b1;
                        rep_cnt_next = CNT_W'(1);
                    end else begin
                        rep_cnt_next = rep_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    rep_state_next = REP_IDLE;
                end
            endcase
        end
    end
`else
    assign repeat_tick = 1'b0;
`endif

    // A clamp on any field takes the whole edge; steps and field select wait.
    always_comb begin
        vals_next   = vals;
        active_next = active;
        clamp_any   = 1'b0;
        for (int k = 0; k < FIELDS; k++) begin
            if (vals[k] > limits[k]) begin
                vals_next[k] = limits[k];
                clamp_any    = 1'b1;
            end
        end
        if (!clamp_any) begin
            if (step_up) begin
                vals_next[active] = (vals[active] >= limits[active]) ? '0
                                  : vals[active] + IDX_W'(1);
            end else if (step_down) begin
                vals_next[active] = (vals[active] == '0) ? limits[active]
                                  : vals[active] - IDX_W'(1);
            end
            if (rise_field) begin
                active_next = (active == LAST_FIELD) ? '0 : active + AF_W'(1);
            end
        end
        change = (vals_next != vals) || (active_next != active);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_right    <= 1'b0;
            prev_left     <= 1'b0;
            prev_field    <= 1'b0;
            vals          <= '0;
            active        <= '0;
            changed       <= 1'b0;
            arduino_out   <= '0;
            arduino_valid <= 1'b0;
        end else begin
            prev_right <= right_arrow_pressed;
            prev_left  <= left_arrow_pressed;
            prev_field <= field_next_pressed;
            if (load_initial) begin
                vals          <= '0;
                active        <= '0;
                changed       <= 1'b0;
                arduino_valid <= 1'b0;
            end else begin
                vals    <= vals_next;
                active  <= active_next;
                changed <= change;
                if (change) begin
                    arduino_out   <= vals_next[active_next];
                    arduino_valid <= 1'b1;
                end else if (arduino_ack) begin
                    arduino_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/menu_navigator.md
# menu_navigator

Parametrised successor to the front-panel menu block. It holds a binary option index for each of `FIELDS` menu fields, with a per-field option limit and wrap-around. Left/right arrows step the active field; an optional hold-to-repeat engine repeats the step while an arrow is held. A field-select button cycles the active field internally. The active field's value goes to the Arduino display link over a valid/ack handshake. It sits between the debounced panel buttons and the game controller, which reads all field values in parallel.

## Interface
Parameters:
- `FIELDS`, 5, number of menu fields (≥2).
- `IDX_W`, 4, width of each field index.
- `HOLD_DELAY`, 50_000_000, cycles an arrow must stay held before the first repeat step.
- `REPEAT_PERIOD`, 10_000_000, cycles between later repeat steps.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `right_arrow_pressed`  in  1  level, debounced; steps the index up.
- `left_arrow_pressed`  in  1  level, debounced; steps the index down.
- `field_next_pressed`  in  1  level, debounced; moves to the next active field.
- `load_initial`  in  1  synchronous reload to initial state.
- `field_limits`  in  FIELDS*IDX_W  per-field maximum index. Field k uses bits [k*IDX_W +: IDX_W].
- `field_values`  out  FIELDS*IDX_W  current index of each field, same packing.
- `active_field`  out  $clog2(FIELDS)  field the arrows act on.
- `changed`  out  1  one-cycle pulse on any index or active-field change.
- `arduino_out`  out  IDX_W  value for the display link.
- `arduino_valid`  out  1  `arduino_out` holds an unacknowledged update.
- `arduino_ack`  in  1  display link consumed `arduino_out`.

## Operation
- **Edge detection:** each of the three buttons has its own previous-sample register.
  - A rising edge is `level & ~prev`.
  - All `prev` registers reset to 0.
- **Step:** a right rising edge or right repeat tick gives +1; a left edge or tick gives −1. Only the active field `a` changes, with limit `L = field_limits[a]`.
  - +1 at `idx == L`, or with `idx > L`, gives 0.
  - −1 at `idx == 0` gives `L`.
  - Otherwise the index becomes `idx ± 1`, modulo IDX_W bits.
- **Both arrows high** in the same cycle: no step, and the repeat counter is cleared. Stepping resumes only on a fresh rising edge after one arrow is released.
- **Limit clamp:** if `field_limits` drops below a field's stored index, that field loads L on the next edge. This counts as a change.
- **Field select:** a `field_next` rising edge sets `active_field` to `(active_field+1) mod FIELDS`.
  - If it coincides with an arrow step, the step applies to the old active field first, then `active_field` advances. Both happen on the same edge.
- **Precedence:** `reset` > `load_initial` > clamp > step/field-select.
  - `load_initial` sets all indices to 0, `active_field` to 0, clears `arduino_valid` and the repeat counter, and does not pulse `changed`.
- **Display handshake:** on any edge where `changed` is produced, `arduino_out` loads the new active field's new index and `arduino_valid` goes to 1.
  - `arduino_valid` clears on an edge where `arduino_ack=1` and no new change occurs.
  - If a change and an ack coincide, valid stays 1 and `arduino_out` carries the new value.
  - `arduino_out` is never updated while `arduino_valid=0`, except through a change.
- **Reset values (reset low, asynchronous):** all of the following are 0: `field_values`, `active_field`, `changed`, `arduino_out`, `arduino_valid`, the repeat counter and all `prev` registers.

## Timing
- Latency from the first sampled-high cycle of a button to the updated `field_values`/`active_field`/`changed`/`arduino_valid` is 1 clock edge.
- `changed` is high for exactly one cycle per change event.
- **Repeat:**
  - The counter starts at the edge-step and counts while exactly one arrow stays high.
  - The first repeat step comes HOLD_DELAY cycles after the edge-step, then one every REPEAT_PERIOD cycles.
  - Release clears the counter on the next edge.
- Reset deassertion mid-hold: no step is produced until a new rising edge, because `prev` came out of reset at 0 and the input level is re-evaluated. A held arrow at deassertion therefore produces one step one edge after release of reset.

## Configuration
- `MENU_AUTOREPEAT_EN` defined: the repeat counter and hold-to-repeat behaviour are compiled in as described.
- Not defined: there is no counter logic. Only rising edges step, one step per press, and HOLD_DELAY/REPEAT_PERIOD are ignored.

## Test plan
- **Reset and wrap:** reset, FIELDS=5, limits all 3. Right pulsed 4 times → field0 goes 1,2,3,0, with `changed` pulsing 4 times. Then one left pulse → 3.
- **Field select and coincidence:** `field_next` pulse → `active_field=1`. Right and `field_next` rising together → field1=1 and `active_field=2` on the same edge.
- **Handshake:** change with no ack → `arduino_valid` held, `arduino_out`=new value. A second change before ack → `arduino_out` updated, valid stays. Ack alone → valid 0 next cycle. Ack together with a change → valid stays 1.
- **Auto-repeat (macro on, HOLD_DELAY=8, REPEAT_PERIOD=3):** hold right for 20 cycles from idx 0, limit 15 → steps at offsets 1, 9, 12, 15, 18, final idx 5. Macro off → idx 1.
- **Both arrows and clamp:** both arrows high → no change. Lower field0 limit from 7 to 2 with idx 5 → idx 2 next edge, `changed` pulses.
- **Asynchronous reset mid-operation:** reset low asynchronously with `arduino_valid=1` → all outputs 0 immediately. `load_initial` → indices 0 with no `changed` pulse.
